// File: rtl/cpu_pkg.sv
// Shared types for the memory stage: load/store opcodes, bus size codes and
// the load/store unit state encoding.
package cpu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    MEMOP_LB  = 3'd0,
    MEMOP_LBU = 3'd1,
    MEMOP_LH  = 3'd2,
    MEMOP_LHU = 3'd3,
    MEMOP_LW  = 3'd4,
    MEMOP_SB  = 3'd5,
    MEMOP_SH  = 3'd6,
    MEMOP_SW  = 3'd7
  } memop_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } lsu_state_e;

  function automatic logic is_store(memop_e op);
    return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW};
  endfunction

  function automatic logic misaligned(memop_e op, logic [1:0] off);
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return off[0];
      MEMOP_LW, MEMOP_SW:            return off != 2'd0;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational lane handling: load byte/half select with extension, and
// store byte-enable / lane-replicated write data generation.
module mem_load_align
  import cpu_pkg::*;
(
  input  memop_e      i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [1:0]  o_size,
  output logic        o_wr,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_size  = SIZE_WORD;
    o_wr    = is_store(i_op);
    o_wstrb = 4'h0;
    o_wdata = 32'h0;
    o_ldata = i_rdata;
    case (i_op)
      MEMOP_LB:  begin o_size = SIZE_BYTE; o_ldata = {{24{w_byte[7]}}, w_byte}; end
      MEMOP_LBU: begin o_size = SIZE_BYTE; o_ldata = {24'h0, w_byte}; end
      MEMOP_LH:  begin o_size = SIZE_HALF; o_ldata = {{16{w_half[15]}}, w_half}; end
      MEMOP_LHU: begin o_size = SIZE_HALF; o_ldata = {16'h0, w_half}; end
      MEMOP_LW:  o_size = SIZE_WORD;
      MEMOP_SB: begin
        o_size  = SIZE_BYTE;
        o_wstrb = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      MEMOP_SH: begin
        o_size  = SIZE_HALF;
        o_wstrb = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      MEMOP_SW: begin
        o_size  = SIZE_WORD;
        o_wstrb = 4'hF;
        o_wdata = i_wdata;
      end
      default: o_size = SIZE_WORD;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: split request/response bus transaction with
// pipeline hold. MEM_LSU_ADDR_EXC_EN enables misaligned-address exceptions.
module mem_lsu
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              valid_i,
  input  logic [2:0]        memop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic [DATA_W-1:0] finaldata_o,
  output logic              stall_o,
  output logic              adel_o,
  output logic              ades_o
);

  lsu_state_e        r_state, w_next;
  memop_e            r_op, w_in_op, w_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_wdata, r_finaldata;
  logic              w_idle, w_err, w_pending, w_req, w_stall, w_latch, w_capture;
  logic [1:0]        w_off, w_size;
  logic              w_wr;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata, w_ldata;

  assign w_in_op = memop_e'(memop_i);
  assign w_idle  = (r_state == ST_IDLE);
  // In IDLE the request is built from live inputs; afterwards from the latch.
  assign w_op    = w_idle ? w_in_op : r_op;
  assign w_off   = w_idle ? addr_i[1:0] : r_addr[1:0];

`ifdef MEM_LSU_ADDR_EXC_EN
  logic w_misal;
  assign w_misal = valid_i && misaligned(w_in_op, addr_i[1:0]);
  assign adel_o  = w_misal && !is_store(w_in_op);
  assign ades_o  = w_misal && is_store(w_in_op);
`else
  assign adel_o  = 1'b0;
  assign ades_o  = 1'b0;
`endif

  assign w_err     = adel_o | ades_o;
  assign w_pending = valid_i && !flush_i && !w_err && !rst_i;

  mem_load_align u_align (
    .i_op    (w_op),
    .i_off   (w_off),
    .i_wdata (wdata_i),
    .i_rdata (data_rdata_i),
    .o_size  (w_size),
    .o_wr    (w_wr),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_stall   = 1'b0;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_req   = 1'b1;
          w_stall = 1'b1;
          w_latch = 1'b1;
          w_next  = data_addr_ok_i ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush_i) begin
          w_next = ST_IDLE;
        end else begin
          w_req   = 1'b1;
          w_stall = w_pending;
          if (data_addr_ok_i) w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_stall = w_pending;
        if (data_data_ok_i) begin
          // A response that races a flush belongs to a dead instruction.
          if (flush_i) begin
            w_next = ST_IDLE;
          end else begin
            w_capture = !r_wr;
            w_next    = ST_DONE;
          end
        end else if (flush_i) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush_i || !stall_i) w_next = ST_IDLE;
      end
      ST_DRAIN: begin
        w_stall = valid_i;
        if (data_data_ok_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_op        <= MEMOP_LB;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_size      <= 2'd0;
      r_wstrb     <= 4'h0;
      r_wdata     <= '0;
      r_finaldata <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_op    <= w_in_op;
        r_addr  <= addr_i;
        r_wr    <= w_wr;
        r_size  <= w_size;
        r_wstrb <= w_wstrb;
        r_wdata <= w_wdata;
      end
      if (w_capture) r_finaldata <= w_ldata;
    end
  end

  assign data_req_o   = w_req;
  assign data_wr_o    = w_req && (w_idle ? w_wr : r_wr);
  assign data_size_o  = w_req ? (w_idle ? w_size : r_size) : 2'd0;
  assign data_addr_o  = w_req ? (w_idle ? addr_i : r_addr) : '0;
  assign data_wstrb_o = w_req ? (w_idle ? w_wstrb : r_wstrb) : 4'h0;
  assign data_wdata_o = w_req ? (w_idle ? w_wdata : r_wdata) : '0;
  assign finaldata_o  = r_finaldata;
  assign stall_o      = w_stall;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: bus responder, randomized driver, and a scoreboard that
// checks every bus request and every completed load against a reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst, flush, stall_in, valid;
  logic [2:0]  memop;
  logic [31:0] addr, wdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] baddr;
  logic [3:0]  wstrb;
  logic [31:0] bwdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata, finaldata;
  logic        stall_o, adel, ades;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          ad;
    int          dd;
    logic [31:0] rd;
  } bus_cfg_t;

  req_t        exp_q[$];
  logic [31:0] exp_fd_q[$];
  bus_cfg_t    cfg_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          fault_op = 1'b0;
  logic [31:0] last_fd = 32'h0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .stall_i        (stall_in),
    .valid_i        (valid),
    .memop_i        (memop),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .data_req_o     (req),
    .data_wr_o      (wr),
    .data_size_o    (size),
    .data_addr_o    (baddr),
    .data_wstrb_o   (wstrb),
    .data_wdata_o   (bwdata),
    .data_addr_ok_i (addr_ok),
    .data_data_ok_i (data_ok),
    .data_rdata_i   (rdata),
    .finaldata_o    (finaldata),
    .stall_o        (stall_o),
    .adel_o         (adel),
    .ades_o         (ades)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: ops are LB,LBU,LH,LHU,LW,SB,SH,SW = 0..7.
  function automatic logic [31:0] model_load(int op, logic [31:0] a, logic [31:0] rd);
    int unsigned off = a & 32'h3;
    logic [31:0] b = (rd >> (8 * off)) & 32'hFF;
    logic [31:0] h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      0:       return (b >= 128) ? b - 32'd256 : b;
      1:       return b;
      2:       return (h >= 32768) ? h - 32'd65536 : h;
      3:       return h;
      default: return rd;
    endcase
  endfunction

  function automatic req_t model_req(int op, logic [31:0] a, logic [31:0] wd);
    req_t r;
    int unsigned off = a & 32'h3;
    r.addr  = a;
    r.wr    = (op >= 5);
    r.size  = (op == 0 || op == 1 || op == 5) ? 2'd0 :
              (op == 2 || op == 3 || op == 6) ? 2'd1 : 2'd2;
    r.wstrb = 4'h0;
    r.wdata = 32'h0;
    if (op == 5) begin
      r.wstrb = 4'(1 << off);
      r.wdata = (wd & 32'hFF) * 32'h0101_0101;
    end else if (op == 6) begin
      r.wstrb = 4'(3 << (2 * (off / 2)));
      r.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    end else if (op == 7) begin
      r.wstrb = 4'hF;
      r.wdata = wd;
    end
    return r;
  endfunction

  // Bus responder: addr_ok after cfg.ad waiting cycles, data_ok cfg.dd cycles
  // after the cycle following acceptance.
  initial begin
    int       ph, ca, cd;
    bit       loaded;
    bus_cfg_t c;
    ph = 0; ca = 0; cd = 0; loaded = 1'b0;
    c.ad = 0; c.dd = 0; c.rd = 32'h0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    forever begin
      @(negedge clk);
      addr_ok = 1'b0;
      data_ok = 1'b0;
      rdata   = $urandom;
      if (rst) begin
        ph = 0; loaded = 1'b0;
      end else if (ph == 1) begin
        if (cd == 0) begin
          data_ok = 1'b1;
          rdata   = c.rd;
          ph      = 0;
        end else cd--;
      end else if (req) begin
        if (!loaded) begin
          if (cfg_q.size() > 0) c = cfg_q.pop_front();
          else begin c.ad = 0; c.dd = 0; c.rd = $urandom; end
          loaded = 1'b1;
          ca     = c.ad;
        end
        if (ca == 0) begin
          addr_ok = 1'b1;
          ph      = 1;
          cd      = c.dd;
          loaded  = 1'b0;
        end else ca--;
      end
    end
  end

  // Monitor: request fields every request cycle, load result while presented.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (req) begin
          if (exp_q.size() == 0) begin
            chk("spurious_req", 72'(1), 72'(0));
          end else begin
            req_t a, e;
            e = exp_q[0];
            a = {wr, size, baddr, wstrb, bwdata};
            if (!e.wr) a.wdata = 32'h0;
            chk("req_fields", 72'(a), 72'(e));
            if (addr_ok) void'(exp_q.pop_front());
          end
        end
        if (valid && !flush && !stall_o && !fault_op && memop <= 3'd4) begin
          if (exp_fd_q.size() == 0) begin
            chk("fd_unexpected", 72'(1), 72'(0));
          end else begin
            chk("finaldata", 72'(finaldata), 72'(exp_fd_q[0]));
            if (!stall_in) void'(exp_fd_q.pop_front());
          end
        end
      end
    end
  end

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ad, input int dd,
                        input int hold, input int extra);
    int       cnt;
    bus_cfg_t c;
    cnt  = 0;
    c.ad = ad; c.dd = dd; c.rd = rd;
    cfg_q.push_back(c);
    exp_q.push_back(model_req(op, a, wd));
    if (op <= 4) begin
      last_fd = model_load(op, a, rd);
      exp_fd_q.push_back(last_fd);
    end
    valid = 1'b1; memop = 3'(op); addr = a; wdata = wd; stall_in = (hold > 0);
    forever begin
      @(negedge clk);
      #2;
      if (!stall_o || cnt > 200) break;
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("stall_cycles", 72'(cnt), 72'(ad + dd + 2 + extra));
    if (op >= 5) chk("store_keeps_fd", 72'(finaldata), 72'(last_fd));
    for (int k = 1; k < hold; k++) begin
      @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      stall_in = 1'b0;
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_cfg_t c;
    rst = 1'b1; flush = 1'b0; stall_in = 1'b0; valid = 1'b0;
    memop = 3'd0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_req", 72'(req), 72'(0));
    chk("rst_stall", 72'(stall_o), 72'(0));
    chk("rst_finaldata", 72'(finaldata), 72'(0));
    chk("rst_bus", 72'({wr, size, baddr, wstrb, bwdata}), 72'(0));
    chk("rst_exc", 72'({adel, ades}), 72'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Sign-extended byte, minimum two-cycle stall.
    run_op(0, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 0, 0);
    // Half store with delayed acceptance.
    run_op(6, 32'h2002, 32'h0000_ABCD, 32'h0, 3, 0, 0, 0);
    // Result held across a downstream stall.
    run_op(3, 32'h10, 32'h0, 32'h1357_9BDF, 0, 1, 3, 0);

    // Flush in WAIT, then a new word load waits for the orphaned response.
    c.ad = 0; c.dd = 3; c.rd = 32'hDEAD_BEEF;
    cfg_q.push_back(c);
    exp_q.push_back(model_req(0, 32'h40, 32'h0));
    valid = 1'b1; memop = 3'd0; addr = 32'h40;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    run_op(4, 32'h44, 32'h0, 32'h1234_5678, 0, 0, 0, 3);

    // Asynchronous reset while the request is waiting for acceptance.
    c.ad = 6; c.dd = 0; c.rd = 32'h0;
    cfg_q.push_back(c);
    exp_q.push_back(model_req(7, 32'h80, 32'h5555_AAAA));
    valid = 1'b1; memop = 3'd7; addr = 32'h80; wdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 72'(req), 72'(0));
    chk("arst_stall", 72'(stall_o), 72'(0));
    chk("arst_finaldata", 72'(finaldata), 72'(0));
    valid = 1'b0;
    exp_q.delete();
    cfg_q.delete();
    last_fd = 32'h0;
    @(negedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef MEM_LSU_ADDR_EXC_EN
    fault_op = 1'b1;
    valid = 1'b1; memop = 3'd4; addr = 32'h6;
    @(negedge clk);
    #2;
    chk("exc_adel", 72'(adel), 72'(1));
    chk("exc_req", 72'(req), 72'(0));
    chk("exc_stall", 72'(stall_o), 72'(0));
    @(posedge clk);
    #1;
    valid = 1'b0;
    fault_op = 1'b0;
`else
    run_op(4, 32'h6, 32'h0, 32'hA5A5_0F0F, 1, 0, 0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 7);
      a  = $urandom;
`ifdef MEM_LSU_ADDR_EXC_EN
      if (op == 2 || op == 3 || op == 6) a[0] = 1'b0;
      if (op == 4 || op == 7) a[1:0] = 2'b00;
`endif
      run_op(op, a, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2), 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("req_queue_drained", 72'(exp_q.size()), 72'(0));
    chk("fd_queue_drained", 72'(exp_fd_q.size()), 72'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
